dtmf_key_decoder: RTL and testbench

Receive-side counterpart of the DTMF tone selector. Takes per-tone detection flags (4 row tones, 4 column tones) from the tone-detector front end. Qualifies a stable single row+column pair for a minimum on-time and maps it back to the 4-bit key code. Presents the code through a one-entry valid/ack holding register read by the Nios-side interface, then requires a minimum silent gap before accepting the next key.

---
 rtl/dtmf_pkg.sv | 53 +++++
 rtl/dtmf_pair_encode.sv | 27 ++
 rtl/dtmf_key_decoder.sv | 171 +++++++++++++++++
 tb/tb_dtmf_key_decoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtmf_pkg.sv
// Shared DTMF definitions: keypad geometry, decoder states and the
// row/column to key-code map used by both the tone selector and the decoder.
package dtmf_pkg;

  localparam int unsigned DTMF_ROWS   = 4;
  localparam int unsigned DTMF_COLS   = 4;
  localparam int unsigned DTMF_IDX_W  = 2;
  localparam int unsigned DTMF_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } dtmf_state_e;

  // Keypad map: rows 0-2 are the telephone digits, row 3 carries E/0/F/D.
  function automatic logic [DTMF_CODE_W-1:0] dtmf_code(
    input logic [DTMF_IDX_W-1:0] row,
    input logic [DTMF_IDX_W-1:0] col
  );
    logic [DTMF_CODE_W-1:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic dtmf_pair_valid(
    input logic [DTMF_ROWS-1:0] row,
    input logic [DTMF_COLS-1:0] col
  );
    return ($countones(row) == 1) && ($countones(col) == 1);
  endfunction

endpackage

// File: rtl/dtmf_pair_encode.sv
// Combinational one-hot row/column pair to key-code encoder.
module dtmf_pair_encode
  import dtmf_pkg::*;
(
  input  logic [DTMF_ROWS-1:0]   i_row,
  input  logic [DTMF_COLS-1:0]   i_col,
  output logic                   o_pair_ok_c,
  output logic [DTMF_CODE_W-1:0] o_code_c
);

  logic [DTMF_IDX_W-1:0] w_row_idx;
  logic [DTMF_IDX_W-1:0] w_col_idx;

  always_comb begin
    w_row_idx = '0;
    w_col_idx = '0;
    for (int i = 0; i < DTMF_ROWS; i++) begin
      if (i_row[i]) w_row_idx = DTMF_IDX_W'(i);
    end
    for (int j = 0; j < DTMF_COLS; j++) begin
      if (i_col[j]) w_col_idx = DTMF_IDX_W'(j);
    end
    o_pair_ok_c = dtmf_pair_valid(i_row, i_col);
    o_code_c    = dtmf_code(w_row_idx, w_col_idx);
  end

endmodule

// File: rtl/dtmf_key_decoder.sv
// DTMF key decoder: qualifies a stable row/column pair, reports it through a
// one-entry valid/ack holding register and enforces a quiet gap between keys.
module dtmf_key_decoder
  import dtmf_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 40,
  parameter int unsigned OFF_CYCLES = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [DTMF_ROWS-1:0]   row_det,
  input  logic [DTMF_COLS-1:0]   col_det,
  input  logic                   key_ack,
  output logic [DTMF_CODE_W-1:0] key_code,
  output logic                   key_valid,
  output logic                   key_down,
  output logic                   overrun,
  output logic                   pair_err
);

  localparam int unsigned CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [DTMF_ROWS-1:0]   r_row;
  logic [DTMF_COLS-1:0]   r_col;
  dtmf_state_e            r_state;
  dtmf_state_e            w_state_n;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_n;
  logic [DTMF_CODE_W-1:0] r_cap;
  logic [DTMF_CODE_W-1:0] w_cap_n;
  logic                   w_commit;
  logic                   w_ok;
  logic [DTMF_CODE_W-1:0] w_code;
  logic                   w_same;
  logic                   w_quiet;
  logic [DTMF_CODE_W-1:0] w_key_code_n;
  logic                   w_key_valid_n;
  logic                   w_key_down_n;
  logic                   w_overrun_n;

  dtmf_pair_encode u_encode (
    .i_row       (r_row),
    .i_col       (r_col),
    .o_pair_ok_c (w_ok),
    .o_code_c    (w_code)
  );

  assign w_same  = w_ok && (w_code == r_cap);
  assign w_quiet = ~(|r_row) && ~(|r_col);

  // Input capture; pair_err is formed from the same sample so it lines up with the registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row    <= '0;
      r_col    <= '0;
      pair_err <= 1'b0;
    end else begin
      r_row    <= row_det;
      r_col    <= col_det;
      pair_err <= ((|row_det) || (|col_det)) && !dtmf_pair_valid(row_det, col_det);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cap   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_cap   <= w_cap_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_cap_n   = r_cap;
    w_commit  = 1'b0;
    if (!en) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ok) begin
            w_cap_n   = w_code;
            w_cnt_n   = CNT_W'(1);
            w_state_n = QUALIFY;
          end
        end
        QUALIFY: begin
          if (w_same) begin
            if (r_cnt >= CNT_W'(ON_CYCLES)) begin
              w_commit  = 1'b1;
              w_cnt_n   = '0;
              w_state_n = PRESSED;
            end else begin
              w_cnt_n = r_cnt + CNT_W'(1);
            end
          end else if (w_ok) begin
            w_cap_n = w_code;
            w_cnt_n = CNT_W'(1);
          end else begin
            w_cnt_n   = '0;
            w_state_n = IDLE;
          end
        end
        PRESSED: begin
          if (!w_same) begin
            w_cnt_n   = '0;
            w_state_n = RELEASE;
          end
        end
        RELEASE: begin
          // Any activity restarts the quiet gap; the gap ends on the edge the count reaches OFF_CYCLES.
          if (!w_quiet) begin
            w_cnt_n = '0;
          end else if (r_cnt >= CNT_W'(OFF_CYCLES - 1)) begin
            w_cnt_n   = '0;
            w_state_n = IDLE;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_cnt_n   = '0;
          w_state_n = IDLE;
        end
      endcase
    end
  end

  // Holding register next values: an ack frees the slot, a commit refills it or flags overrun.
  always_comb begin
    w_key_code_n  = key_code;
    w_key_valid_n = key_valid;
    w_overrun_n   = overrun;
    w_key_down_n  = (w_state_n == PRESSED);
    if (key_ack && key_valid) begin
      w_key_valid_n = 1'b0;
      w_overrun_n   = 1'b0;
    end
    if (w_commit) begin
      if (!key_valid || key_ack) begin
        w_key_code_n  = r_cap;
        w_key_valid_n = 1'b1;
      end else begin
        w_overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      key_code  <= w_key_code_n;
      key_valid <= w_key_valid_n;
      key_down  <= w_key_down_n;
      overrun   <= w_overrun_n;
    end
  end

endmodule

// File: tb/tb_dtmf_key_decoder.sv
// Randomized and directed bench for dtmf_key_decoder against a run-length
// reference model of key qualification, quiet gap and the holding register.
module tb_dtmf_key_decoder;

  localparam int ON_P  = 4;
  localparam int OFF_P = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] row_det;
  logic [3:0] col_det;
  logic       key_ack;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       overrun;
  logic       pair_err;

  int n_checks = 0;
  int n_fail   = 0;

  dtmf_key_decoder #(.ON_CYCLES(ON_P), .OFF_CYCLES(OFF_P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .row_det   (row_det),
    .col_det   (col_det),
    .key_ack   (key_ack),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .overrun   (overrun),
    .pair_err  (pair_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] code_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] m_prev_row, m_prev_col, m_run_code, m_code;
  int         m_run, m_quiet;
  bit         m_held, m_rel, m_valid, m_ovr, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pair_ok(input logic [3:0] r, input logic [3:0] c);
    return ($countones(r) == 1) && ($countones(c) == 1);
  endfunction

  function automatic logic [3:0] m_pair_code(input logic [3:0] r, input logic [3:0] c);
    int ri, ci;
    ri = 0;
    ci = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) ri = i;
      if (c[i]) ci = i;
    end
    return code_tbl[ri*4 + ci];
  endfunction

  task automatic model_reset();
    m_prev_row = '0; m_prev_col = '0; m_run_code = '0; m_code = '0;
    m_run = 0; m_quiet = 0;
    m_held = 0; m_rel = 0; m_valid = 0; m_ovr = 0; m_err = 0;
  endtask

  // One clock edge of the model: decisions use the inputs sampled on the previous edge.
  task automatic model_edge(input logic [3:0] r, input logic [3:0] c, input bit a, input bit e);
    bit ok, commit, was_valid;
    logic [3:0] code;
    ok        = m_pair_ok(m_prev_row, m_prev_col);
    code      = m_pair_code(m_prev_row, m_prev_col);
    commit    = 0;
    was_valid = m_valid;
    if (!e) begin
      m_held = 0; m_rel = 0; m_run = 0; m_quiet = 0;
    end else if (m_held) begin
      if (!(ok && code == m_run_code)) begin
        m_held = 0; m_rel = 1; m_quiet = 0;
      end
    end else if (m_rel) begin
      if (m_prev_row == 0 && m_prev_col == 0) begin
        m_quiet++;
        if (m_quiet == OFF_P) begin
          m_rel = 0; m_run = 0;
        end
      end else begin
        m_quiet = 0;
      end
    end else if (ok) begin
      if (m_run > 0 && code == m_run_code) m_run++;
      else begin
        m_run = 1; m_run_code = code;
      end
      if (m_run == ON_P + 1) begin
        commit = 1; m_held = 1; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (a && was_valid) begin
      m_valid = 0; m_ovr = 0;
    end
    if (commit) begin
      if (!was_valid || a) begin
        m_code = m_run_code; m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end
    m_err      = ((r | c) != 0) && !m_pair_ok(r, c);
    m_prev_row = r;
    m_prev_col = c;
  endtask

  task automatic compare_all();
    check("key_code", 32'(key_code), 32'(m_code));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_down", 32'(key_down), 32'(m_held));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("pair_err", 32'(pair_err), 32'(m_err));
  endtask

  // Drive after a falling edge, clock once, compare on the next falling edge.
  task automatic step(input logic [3:0] r, input logic [3:0] c, input bit a, input bit e);
    row_det = r; col_det = c; key_ack = a; en = e;
    @(posedge clk);
    model_edge(r, c, a, e);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [3:0] r, input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) step(r, c, 1'b0, 1'b1);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0; row_det = '0; col_det = '0; key_ack = 1'b0; en = 1'b1;
    #1;
    check({tag, "_code"}, 32'(key_code), 32'h0);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_down"}, 32'(key_down), 32'h0);
    check({tag, "_ovr"}, 32'(overrun), 32'h0);
    check({tag, "_err"}, 32'(pair_err), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int len, kind, qlen;
    logic [3:0] r, c;
    rst_n = 1'b0; en = 1'b1; row_det = '0; col_det = '0; key_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Key 2: latency to key_valid, key_down while held, ack clears
    n = 0;
    do begin
      step(4'b0001, 4'b0010, 1'b0, 1'b1);
      n++;
    end while (!key_valid && n < 20);
    check("latency_key2", 32'(n), 32'(ON_P + 2));
    check("key2_code", 32'(key_code), 32'h2);
    hold(4'b0001, 4'b0010, 2);
    check("key2_down", 32'(key_down), 32'h1);
    hold(4'b0000, 4'b0000, OFF_P + 2);
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    check("key2_acked", 32'(key_valid), 32'h0);

    // Short pulse of key 0 is rejected, then the full hold reports it
    hold(4'b1000, 4'b0010, 3);
    hold(4'b0000, 4'b0000, 3);
    check("pulse_no_valid", 32'(key_valid), 32'h0);
    hold(4'b1000, 4'b0010, ON_P + 3);
    check("key0_code", 32'(key_code), 32'h0);
    check("key0_valid", 32'(key_valid), 32'h1);
    hold(4'b0000, 4'b0000, OFF_P + 1);
    step(4'b0000, 4'b0000, 1'b1, 1'b1);

    // Key 5, glitch inside the quiet gap, key 5 again
    hold(4'b0010, 4'b0010, ON_P + 3);
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    hold(4'b0000, 4'b0000, 1);
    hold(4'b0010, 4'b0000, 1);
    hold(4'b0000, 4'b0000, 3);
    hold(4'b0010, 4'b0010, ON_P + 3);
    check("key5_again", 32'(key_valid), 32'h1);
    hold(4'b0000, 4'b0000, OFF_P + 1);
    step(4'b0000, 4'b0000, 1'b1, 1'b1);

    // Overrun: 9 unread, then D dropped; then ack coinciding with C commit
    hold(4'b0100, 4'b0100, ON_P + 3);
    hold(4'b0000, 4'b0000, OFF_P + 2);
    hold(4'b1000, 4'b1000, ON_P + 3);
    hold(4'b0000, 4'b0000, OFF_P + 2);
    check("ovr_code9", 32'(key_code), 32'h9);
    check("ovr_set", 32'(overrun), 32'h1);
    for (int i = 0; i < ON_P + 3; i++) step(4'b0100, 4'b1000, (i == ON_P + 1), 1'b1);
    check("ackc_code", 32'(key_code), 32'hC);
    check("ackc_valid", 32'(key_valid), 32'h1);
    check("ackc_ovr", 32'(overrun), 32'h0);
    hold(4'b0000, 4'b0000, OFF_P + 2);

    // Two rows with one column: pair_err, no commit
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    hold(4'b0011, 4'b0001, ON_P + 3);
    check("perr_flag", 32'(pair_err), 32'h1);
    check("perr_nocommit", 32'(key_valid), 32'h0);
    hold(4'b0000, 4'b0000, 2);

    // Async reset mid-QUALIFY and mid-PRESSED
    hold(4'b0001, 4'b0001, 3);
    async_reset("rst_qual");
    hold(4'b0010, 4'b0100, ON_P + 3);
    async_reset("rst_press");
    hold(4'b0000, 4'b0000, 2);

    // Enable drop during key 7 qualify keeps the held 8; ack still works while disabled
    hold(4'b0100, 4'b0010, ON_P + 3);
    hold(4'b0000, 4'b0000, OFF_P + 2);
    hold(4'b0100, 4'b0001, 2);
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0001, 1'b0, 1'b0);
    check("en0_valid_kept", 32'(key_valid), 32'h1);
    check("en0_code_kept", 32'(key_code), 32'h8);
    step(4'b0100, 4'b0001, 1'b1, 1'b0);
    check("en0_ack", 32'(key_valid), 32'h0);
    n = 0;
    do begin
      step(4'b0100, 4'b0001, 1'b0, 1'b1);
      n++;
    end while (!key_valid && n < 20);
    check("reen_latency", 32'(n), 32'(ON_P + 1));
    check("reen_code7", 32'(key_code), 32'h7);
    hold(4'b0000, 4'b0000, OFF_P + 2);

    // Randomized segments
    for (int s = 0; s < 250; s++) begin
      len  = $urandom_range(1, ON_P + 4);
      kind = $urandom_range(0, 9);
      if (kind <= 6 || kind == 9) begin
        r = 4'(1 << $urandom_range(0, 3));
        c = 4'(1 << $urandom_range(0, 3));
      end else if (kind == 7) begin
        r = 4'($urandom_range(1, 15));
        c = 4'($urandom_range(0, 15));
      end else begin
        r = '0;
        c = '0;
      end
      for (int i = 0; i < len; i++)
        step(r, c, ($urandom_range(0, 3) == 0), !(kind == 9 && i == 1));
      qlen = $urandom_range(0, OFF_P + 2);
      for (int i = 0; i < qlen; i++)
        step(4'b0000, 4'b0000, ($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
